clock_mode_fsm: RTL and testbench
=================================

// Module: clock_mode_fsm
// PURPOSE
//  Mode state machine between the ButtonDebouncer outputs and the buzzer/light/display controllers.
//  - Owns the time-set edit buffer and the alarm registers.
//  - Detects the alarm match and drives `state`, which the controllers decode.
//  - Loads new time into the time counter via a one-cycle set_load strobe.
// PARAMETERS
//  RING_SECONDS     60  ring auto-stops after this many tick_1hz pulses
//  TIMEOUT_SECONDS  30  idle seconds before an edit state auto-returns to S_CLOCK (AUTO_RETURN_EN only)
//  ALARM_HOUR_RST    7  alarm_hour value at reset
//  ALARM_MIN_RST     0  alarm_min value at reset
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-high reset
//  btn_mode    in   1  debounced one-cycle pulse: advance mode
//  btn_sel     in   1  debounced one-cycle pulse: toggle alarm enable (S_CLOCK only)
//  btn_up      in   1  debounced one-cycle pulse: increment field being edited
//  btn_down    in   1  debounced one-cycle pulse: decrement field being edited
//  tick_1hz    in   1  one-cycle pulse per second from the time counter
//  cur_hour    in   5  current hour, 0..23
//  cur_min     in   6  current minute, 0..59
//  cur_sec     in   6  current second, 0..59
//  state       out  3  0 CLOCK, 1 SET_HOUR, 2 SET_MIN, 3 ALM_HOUR, 4 ALM_MIN, 5 RING
//  edit_hour   out  5  time-set edit buffer, hour field
//  edit_min    out  6  time-set edit buffer, minute field
//  set_load    out  1  one-cycle strobe; time counter loads edit_hour:edit_min:00
//  alarm_hour  out  5  alarm hour, 0..23
//  alarm_min   out  6  alarm minute, 0..59
//  alarm_en    out  1  alarm armed
//  ring        out  1  high while state==RING (buzzer request)
// BEHAVIOUR
//  - Reset values:
//    - state=CLOCK; edit_hour=0; edit_min=0; set_load=0.
//    - alarm_hour=ALARM_HOUR_RST; alarm_min=ALARM_MIN_RST; alarm_en=0; ring=0.
//    - All counters are cleared.
//    - Reset asserted mid-edit discards the edit with no set_load.
//  - All outputs are registered. Every transition takes effect on the clk edge that samples the pulse.
//  - btn_mode transitions:
//    - CLOCK->SET_HOUR: edit_hour<=cur_hour, edit_min<=cur_min in the same cycle.
//    - SET_HOUR->SET_MIN.
//    - SET_MIN->ALM_HOUR: set_load=1 for exactly the next cycle.
//    - ALM_HOUR->ALM_MIN.
//    - ALM_MIN->CLOCK.
//  - btn_up/btn_down edit only the active field:
//    - SET_HOUR: edit_hour.  SET_MIN: edit_min.
//    - ALM_HOUR: alarm_hour.  ALM_MIN: alarm_min.
//    - Wrap-around: hour 23+1->0, 0-1->23; minute 59+1->0, 0-1->59.
//    - In CLOCK, btn_up/btn_down are ignored.
//  - Simultaneous pulses in one cycle:
//    - btn_mode wins and all other pulses are dropped.
//    - btn_up together with btn_down: no change.
//  - btn_sel in CLOCK toggles alarm_en. Ignored in all other states.
//  - Alarm match:
//    - Condition: state==CLOCK && alarm_en && tick_1hz && cur_hour==alarm_hour && cur_min==alarm_min && cur_sec==0.
//    - On match: RING next cycle, ring=1, ring counter cleared.
//    - A match while in any edit state is missed. No deferred ring.
//  - RING:
//    - Counts tick_1hz pulses.
//    - Any button pulse, or count==RING_SECONDS, returns to CLOCK and ring=0 the same edge.
//    - The button press that exits RING has no other effect.
//    - alarm_en stays 1 after ring.
//  - Counter widths: $clog2(max(RING_SECONDS,TIMEOUT_SECONDS)+1) bits; must not overflow.
// CONFIGURATION
//  AUTO_RETURN_EN defined:
//  - In SET_HOUR, SET_MIN, ALM_HOUR and ALM_MIN, an idle counter counts tick_1hz pulses.
//  - Any button pulse clears the counter.
//  - At TIMEOUT_SECONDS the FSM returns to CLOCK:
//    - Pending time edit is discarded, no set_load.
//    - Alarm edits already made are kept.
//  - The counter clears on entry to each edit state.
//  AUTO_RETURN_EN undefined: no idle counter; edit states persist indefinitely.
// TESTING
//  1. Reset, cur=10:20:05, pulse btn_mode, 3x btn_up, btn_mode, 41x btn_down, btn_mode
//     -> edit=13:39, set_load high exactly 1 cycle, state=3.
//  2. SET_HOUR with edit_hour=23, btn_up -> 0; then btn_down -> 23.
//     SET_MIN with edit_min=0, btn_down -> 59.
//  3. alarm=07:00, btn_sel (alarm_en=1), drive cur 07:00:00 with tick_1hz
//     -> state=5, ring=1 next cycle; btn_up pulse -> state=0, ring=0, alarm_en=1.
//  4. Ring with no buttons: after RING_SECONDS ticks -> state=0, ring=0.
//     Same match while state=1 -> no ring.
//  5. btn_mode and btn_up in the same cycle in SET_HOUR -> state=2, edit_hour unchanged.
//     btn_up and btn_down together -> no change.
//  6. AUTO_RETURN_EN: enter SET_MIN, idle TIMEOUT_SECONDS ticks -> state=0, set_load never asserts.
//     Assert rst mid-SET_MIN -> all reset values immediately.

Source files
------------

// File: rtl/clock_mode_fsm.sv
`default_nettype none
// ============================================================================
// Module      : clock_mode_fsm
// Description : Mode state machine for the alarm clock. Sits between the
//               debounced button pulses and the buzzer/light/display
//               controllers. Owns the time-set edit buffer and the alarm
//               registers, detects the alarm match, and issues a one-cycle
//               set_load strobe so the time counter loads the edited time.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro:
//   AUTO_RETURN_EN - when defined, an idle counter in every edit state
//                    returns the FSM to S_CLOCK after TIMEOUT_SECONDS ticks
//                    without a button press. Undefined: edit states persist.
// ----------------------------------------------------------------------------
// Ports:
//   clk         in   1  system clock
//   rst         in   1  asynchronous, active-high reset
//   btn_mode    in   1  pulse: advance mode
//   btn_sel     in   1  pulse: toggle alarm enable (S_CLOCK only)
//   btn_up      in   1  pulse: increment the field being edited
//   btn_down    in   1  pulse: decrement the field being edited
//   tick_1hz    in   1  one-cycle pulse per second
//   cur_hour    in   5  current hour 0..23
//   cur_min     in   6  current minute 0..59
//   cur_sec     in   6  current second 0..59
//   state       out  3  0 CLOCK,1 SET_HOUR,2 SET_MIN,3 ALM_HOUR,4 ALM_MIN,5 RING
//   edit_hour   out  5  time-set edit buffer, hour
//   edit_min    out  6  time-set edit buffer, minute
//   set_load    out  1  one-cycle strobe: load edit_hour:edit_min:00
//   alarm_hour  out  5  alarm hour
//   alarm_min   out  6  alarm minute
//   alarm_en    out  1  alarm armed
//   ring        out  1  high while in RING
// ============================================================================
module clock_mode_fsm #(
  parameter int RING_SECONDS    = 60,
  parameter int TIMEOUT_SECONDS = 30,
  parameter int ALARM_HOUR_RST  = 7,
  parameter int ALARM_MIN_RST   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [2:0] state,
  output logic [4:0] edit_hour,
  output logic [5:0] edit_min,
  output logic       set_load,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       alarm_en,
  output logic       ring
);

  localparam logic [2:0] S_CLOCK    = 3'd0;
  localparam logic [2:0] S_SET_HOUR = 3'd1;
  localparam logic [2:0] S_SET_MIN  = 3'd2;
  localparam logic [2:0] S_ALM_HOUR = 3'd3;
  localparam logic [2:0] S_ALM_MIN  = 3'd4;
  localparam logic [2:0] S_RING     = 3'd5;

  // One seconds counter is shared between RING and the edit states since
  // they are mutually exclusive; it is sized for the larger of the limits.
  localparam int CNT_MAX = (RING_SECONDS > TIMEOUT_SECONDS) ? RING_SECONDS : TIMEOUT_SECONDS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Exits fire on the edge that samples the final tick, so the counter
  // compares against limit-1 and never exceeds the limit.
  localparam logic [CNT_W-1:0] RING_LAST    = CNT_W'(RING_SECONDS - 1);
`ifdef AUTO_RETURN_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_SECONDS - 1);
`endif

  localparam logic [4:0] ALARM_HOUR_INIT = 5'(ALARM_HOUR_RST);
  localparam logic [5:0] ALARM_MIN_INIT  = 6'(ALARM_MIN_RST);

  logic [2:0]       state_q,      state_d;
  logic [4:0]       edit_hour_q,  edit_hour_d;
  logic [5:0]       edit_min_q,   edit_min_d;
  logic             set_load_q,   set_load_d;
  logic [4:0]       alarm_hour_q, alarm_hour_d;
  logic [5:0]       alarm_min_q,  alarm_min_d;
  logic             alarm_en_q,   alarm_en_d;
  logic             ring_q,       ring_d;
  logic [CNT_W-1:0] sec_cnt_q,    sec_cnt_d;

  logic any_btn;
  logic step;      // exactly one of up/down is pressed
  logic step_up;   // direction when step is set
  logic alarm_match;

  // Wrapping hour/minute steppers.
  function automatic logic [4:0] hour_step(input logic [4:0] h, input logic up);
    if (up) hour_step = (h >= 5'd23) ? 5'd0 : h + 5'd1;
    else    hour_step = (h == 5'd0)  ? 5'd23 : h - 5'd1;
  endfunction

  function automatic logic [5:0] min_step(input logic [5:0] m, input logic up);
    if (up) min_step = (m >= 6'd59) ? 6'd0 : m + 6'd1;
    else    min_step = (m == 6'd0)  ? 6'd59 : m - 6'd1;
  endfunction

  always_comb begin
    any_btn     = btn_mode | btn_sel | btn_up | btn_down;
    step        = btn_up ^ btn_down;
    step_up     = btn_up;
    alarm_match = (state_q == S_CLOCK) && alarm_en_q && tick_1hz &&
                  (cur_hour == alarm_hour_q) && (cur_min == alarm_min_q) &&
                  (cur_sec == 6'd0);
  end

  always_comb begin
    state_d      = state_q;
    edit_hour_d  = edit_hour_q;
    edit_min_d   = edit_min_q;
    set_load_d   = 1'b0;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    alarm_en_d   = alarm_en_q;
    sec_cnt_d    = sec_cnt_q;

    case (state_q)
      S_CLOCK: begin
        sec_cnt_d = '0;
        // btn_mode has priority over everything else in the same cycle,
        // including a coincident alarm match.
        if (btn_mode) begin
          state_d     = S_SET_HOUR;
          edit_hour_d = cur_hour;
          edit_min_d  = cur_min;
        end else if (alarm_match) begin
          state_d = S_RING;
        end else if (btn_sel) begin
          alarm_en_d = ~alarm_en_q;
        end
      end

      S_SET_HOUR: begin
        if (btn_mode)  state_d = S_SET_MIN;
        else if (step) edit_hour_d = hour_step(edit_hour_q, step_up);
      end

      S_SET_MIN: begin
        if (btn_mode) begin
          state_d    = S_ALM_HOUR;
          set_load_d = 1'b1;
        end else if (step) begin
          edit_min_d = min_step(edit_min_q, step_up);
        end
      end

      S_ALM_HOUR: begin
        if (btn_mode)  state_d = S_ALM_MIN;
        else if (step) alarm_hour_d = hour_step(alarm_hour_q, step_up);
      end

      S_ALM_MIN: begin
        if (btn_mode)  state_d = S_CLOCK;
        else if (step) alarm_min_d = min_step(alarm_min_q, step_up);
      end

      S_RING: begin
        // Any button only silences the ring; it has no other effect.
        if (any_btn || (tick_1hz && (sec_cnt_q == RING_LAST))) begin
          state_d   = S_CLOCK;
          sec_cnt_d = '0;
        end else if (tick_1hz) begin
          sec_cnt_d = sec_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = S_CLOCK;
        sec_cnt_d = '0;
      end
    endcase

`ifdef AUTO_RETURN_EN
    // Idle timeout in the edit states. Leaving via timeout keeps any alarm
    // edits already written and never raises set_load, so a pending time
    // edit is simply dropped.
    if ((state_q == S_SET_HOUR) || (state_q == S_SET_MIN) ||
        (state_q == S_ALM_HOUR) || (state_q == S_ALM_MIN)) begin
      if (any_btn) begin
        sec_cnt_d = '0;
      end else if (tick_1hz) begin
        if (sec_cnt_q == TIMEOUT_LAST) begin
          state_d   = S_CLOCK;
          sec_cnt_d = '0;
        end else begin
          sec_cnt_d = sec_cnt_q + 1'b1;
        end
      end
    end
`endif

    ring_d = (state_d == S_RING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_CLOCK;
      edit_hour_q  <= 5'd0;
      edit_min_q   <= 6'd0;
      set_load_q   <= 1'b0;
      alarm_hour_q <= ALARM_HOUR_INIT;
      alarm_min_q  <= ALARM_MIN_INIT;
      alarm_en_q   <= 1'b0;
      ring_q       <= 1'b0;
      sec_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      edit_hour_q  <= edit_hour_d;
      edit_min_q   <= edit_min_d;
      set_load_q   <= set_load_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      alarm_en_q   <= alarm_en_d;
      ring_q       <= ring_d;
      sec_cnt_q    <= sec_cnt_d;
    end
  end

  assign state      = state_q;
  assign edit_hour  = edit_hour_q;
  assign edit_min   = edit_min_q;
  assign set_load   = set_load_q;
  assign alarm_hour = alarm_hour_q;
  assign alarm_min  = alarm_min_q;
  assign alarm_en   = alarm_en_q;
  assign ring       = ring_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_mode_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_mode_fsm
// Description : Self-checking bench for clock_mode_fsm. Table of directed
//               button vectors followed by hand-written multi-cycle sequences
//               (alarm ring, ring timeout, missed match, idle timeout, async
//               reset mid-edit). Honours AUTO_RETURN_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_mode_fsm;

  localparam int RING_S = 60;
  localparam int TO_S   = 30;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_MODE = 5'b10000;
  localparam logic [4:0] B_SEL  = 5'b01000;
  localparam logic [4:0] B_UP   = 5'b00100;
  localparam logic [4:0] B_DN   = 5'b00010;
  localparam logic [4:0] B_TICK = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_sel = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [4:0] cur_hour = 5'd10;
  logic [5:0] cur_min = 6'd20;
  logic [5:0] cur_sec = 6'd5;
  logic [2:0] state;
  logic [4:0] edit_hour, alarm_hour;
  logic [5:0] edit_min, alarm_min;
  logic       set_load, alarm_en, ring;

  clock_mode_fsm #(
    .RING_SECONDS(RING_S), .TIMEOUT_SECONDS(TO_S),
    .ALARM_HOUR_RST(7), .ALARM_MIN_RST(0)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_sel(btn_sel), .btn_up(btn_up), .btn_down(btn_down),
    .tick_1hz(tick_1hz), .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .state(state), .edit_hour(edit_hour), .edit_min(edit_min), .set_load(set_load),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_en(alarm_en), .ring(ring)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] btn;
    int         reps;
    logic [2:0] st;
    logic [4:0] eh;
    logic [5:0] em;
    logic       sl;
    logic [4:0] ah;
    logic [5:0] am;
    logic       en;
  } vec_t;

  vec_t tbl[28];

  logic [27:0] dut_out;
  assign dut_out = {state, edit_hour, edit_min, set_load, alarm_hour, alarm_min, alarm_en, ring};

  function automatic vec_t mk(logic [4:0] b, int r, logic [2:0] st, logic [4:0] eh,
                              logic [5:0] em, logic sl, logic [4:0] ah, logic [5:0] am,
                              logic en);
    vec_t v;
    v.btn = b; v.reps = r; v.st = st; v.eh = eh; v.em = em;
    v.sl = sl; v.ah = ah; v.am = am; v.en = en;
    return v;
  endfunction

  // Expected packed outputs; ring is expected high exactly in state 5.
  function automatic logic [27:0] exp_pack(logic [2:0] st, logic [4:0] eh, logic [5:0] em,
                                           logic sl, logic [4:0] ah, logic [5:0] am,
                                           logic en);
    return {st, eh, em, sl, ah, am, en, (st == 3'd5)};
  endfunction

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d eh=%0d em=%0d sl=%0b ah=%0d am=%0d en=%0b ring=%0b, expected st=%0d eh=%0d em=%0d sl=%0b ah=%0d am=%0d en=%0b ring=%0b",
               name, act[27:25], act[24:20], act[19:14], act[13], act[12:8], act[7:2], act[1], act[0],
               exp[27:25], exp[24:20], exp[19:14], exp[13], exp[12:8], exp[7:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Drive one cycle of pulses; returns at posedge+1 with pulses cleared.
  task automatic drive(input logic [4:0] b);
    {btn_mode, btn_sel, btn_up, btn_down, tick_1hz} = b;
    @(posedge clk);
    #1;
    {btn_mode, btn_sel, btn_up, btn_down, tick_1hz} = B_NONE;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic sl_seen;

  initial begin
    // Table: cur time held at 10:20:05, no ticks.
    tbl[0]  = mk(B_NONE,        1, 3'd0,  5'd0,  6'd0, 1'b0, 5'd7, 6'd0,  1'b0);
    tbl[1]  = mk(B_MODE,        1, 3'd1, 5'd10, 6'd20, 1'b0, 5'd7, 6'd0,  1'b0);
    tbl[2]  = mk(B_UP,          3, 3'd1, 5'd13, 6'd20, 1'b0, 5'd7, 6'd0,  1'b0);
    tbl[3]  = mk(B_MODE,        1, 3'd2, 5'd13, 6'd20, 1'b0, 5'd7, 6'd0,  1'b0);
    tbl[4]  = mk(B_DN,         41, 3'd2, 5'd13, 6'd39, 1'b0, 5'd7, 6'd0,  1'b0);
    tbl[5]  = mk(B_MODE,        1, 3'd3, 5'd13, 6'd39, 1'b1, 5'd7, 6'd0,  1'b0);
    tbl[6]  = mk(B_NONE,        1, 3'd3, 5'd13, 6'd39, 1'b0, 5'd7, 6'd0,  1'b0);
    tbl[7]  = mk(B_UP,          1, 3'd3, 5'd13, 6'd39, 1'b0, 5'd8, 6'd0,  1'b0);
    tbl[8]  = mk(B_DN,          2, 3'd3, 5'd13, 6'd39, 1'b0, 5'd6, 6'd0,  1'b0);
    tbl[9]  = mk(B_MODE | B_UP, 1, 3'd4, 5'd13, 6'd39, 1'b0, 5'd6, 6'd0,  1'b0);
    tbl[10] = mk(B_DN,          1, 3'd4, 5'd13, 6'd39, 1'b0, 5'd6, 6'd59, 1'b0);
    tbl[11] = mk(B_UP,          1, 3'd4, 5'd13, 6'd39, 1'b0, 5'd6, 6'd0,  1'b0);
    tbl[12] = mk(B_UP | B_DN,   1, 3'd4, 5'd13, 6'd39, 1'b0, 5'd6, 6'd0,  1'b0);
    tbl[13] = mk(B_MODE,        1, 3'd0, 5'd13, 6'd39, 1'b0, 5'd6, 6'd0,  1'b0);
    tbl[14] = mk(B_UP,          1, 3'd0, 5'd13, 6'd39, 1'b0, 5'd6, 6'd0,  1'b0);
    tbl[15] = mk(B_SEL,         1, 3'd0, 5'd13, 6'd39, 1'b0, 5'd6, 6'd0,  1'b1);
    tbl[16] = mk(B_SEL,         1, 3'd0, 5'd13, 6'd39, 1'b0, 5'd6, 6'd0,  1'b0);
    tbl[17] = mk(B_MODE,        1, 3'd1, 5'd10, 6'd20, 1'b0, 5'd6, 6'd0,  1'b0);
    tbl[18] = mk(B_UP,         13, 3'd1, 5'd23, 6'd20, 1'b0, 5'd6, 6'd0,  1'b0);
    tbl[19] = mk(B_UP,          1, 3'd1,  5'd0, 6'd20, 1'b0, 5'd6, 6'd0,  1'b0);
    tbl[20] = mk(B_DN,          1, 3'd1, 5'd23, 6'd20, 1'b0, 5'd6, 6'd0,  1'b0);
    tbl[21] = mk(B_MODE | B_UP, 1, 3'd2, 5'd23, 6'd20, 1'b0, 5'd6, 6'd0,  1'b0);
    tbl[22] = mk(B_UP | B_DN,   1, 3'd2, 5'd23, 6'd20, 1'b0, 5'd6, 6'd0,  1'b0);
    tbl[23] = mk(B_DN,         20, 3'd2, 5'd23,  6'd0, 1'b0, 5'd6, 6'd0,  1'b0);
    tbl[24] = mk(B_DN,          1, 3'd2, 5'd23, 6'd59, 1'b0, 5'd6, 6'd0,  1'b0);
    tbl[25] = mk(B_MODE,        1, 3'd3, 5'd23, 6'd59, 1'b1, 5'd6, 6'd0,  1'b0);
    tbl[26] = mk(B_MODE,        1, 3'd4, 5'd23, 6'd59, 1'b0, 5'd6, 6'd0,  1'b0);
    tbl[27] = mk(B_MODE,        1, 3'd0, 5'd23, 6'd59, 1'b0, 5'd6, 6'd0,  1'b0);

    // Reset state, both while asserted and after release.
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", dut_out, exp_pack(3'd0, 5'd0, 6'd0, 1'b0, 5'd7, 6'd0, 1'b0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_released", dut_out, exp_pack(3'd0, 5'd0, 6'd0, 1'b0, 5'd7, 6'd0, 1'b0));

    for (int i = 0; i < 28; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) drive(tbl[i].btn);
      check($sformatf("vec%0d", i), dut_out,
            exp_pack(tbl[i].st, tbl[i].eh, tbl[i].em, tbl[i].sl, tbl[i].ah, tbl[i].am, tbl[i].en));
    end

    // Alarm match -> ring; a button silences it with no other effect.
    pulse_reset();
    drive(B_SEL);
    cur_hour = 5'd7; cur_min = 6'd0; cur_sec = 6'd0;
    drive(B_TICK);
    check("alarm_ring", dut_out, exp_pack(3'd5, 5'd0, 6'd0, 1'b0, 5'd7, 6'd0, 1'b1));
    drive(B_NONE);
    check("ring_holds", dut_out, exp_pack(3'd5, 5'd0, 6'd0, 1'b0, 5'd7, 6'd0, 1'b1));
    drive(B_UP);
    check("ring_btn_exit", dut_out, exp_pack(3'd0, 5'd0, 6'd0, 1'b0, 5'd7, 6'd0, 1'b1));

    // Ring with no buttons stops after RING_S ticks.
    drive(B_TICK);
    check("ring_again", dut_out, exp_pack(3'd5, 5'd0, 6'd0, 1'b0, 5'd7, 6'd0, 1'b1));
    cur_sec = 6'd1;
    for (int i = 0; i < RING_S - 1; i++) begin
      drive(B_TICK);
      drive(B_NONE);
    end
    check("ring_before_limit", dut_out, exp_pack(3'd5, 5'd0, 6'd0, 1'b0, 5'd7, 6'd0, 1'b1));
    drive(B_TICK);
    check("ring_timeout", dut_out, exp_pack(3'd0, 5'd0, 6'd0, 1'b0, 5'd7, 6'd0, 1'b1));

    // Match while editing is missed and not deferred.
    drive(B_MODE);
    cur_sec = 6'd0;
    drive(B_TICK);
    check("missed_match", dut_out, exp_pack(3'd1, 5'd7, 6'd0, 1'b0, 5'd7, 6'd0, 1'b1));
    repeat (4) drive(B_MODE);
    cur_sec = 6'd1;
    drive(B_TICK);
    check("no_deferred_ring", dut_out, exp_pack(3'd0, 5'd7, 6'd0, 1'b0, 5'd7, 6'd0, 1'b1));

    // Idle in SET_MIN for TO_S ticks.
    cur_hour = 5'd10; cur_min = 6'd20; cur_sec = 6'd5;
    drive(B_MODE);
    drive(B_MODE);
    sl_seen = 1'b0;
    for (int i = 0; i < TO_S - 1; i++) begin
      drive(B_TICK);
      sl_seen = sl_seen | set_load;
    end
    check("idle_before_limit", dut_out, exp_pack(3'd2, 5'd10, 6'd20, 1'b0, 5'd7, 6'd0, 1'b1));
    drive(B_TICK);
    sl_seen = sl_seen | set_load;
    drive(B_NONE);
    sl_seen = sl_seen | set_load;
`ifdef AUTO_RETURN_EN
    check("idle_timeout", dut_out, exp_pack(3'd0, 5'd10, 6'd20, 1'b0, 5'd7, 6'd0, 1'b1));
`else
    check("idle_persist", dut_out, exp_pack(3'd2, 5'd10, 6'd20, 1'b0, 5'd7, 6'd0, 1'b1));
`endif
    check_bit("idle_no_set_load", sl_seen, 1'b0);

    // Async reset mid SET_MIN after alarm changes discards everything.
    pulse_reset();
    repeat (3) drive(B_MODE);
    drive(B_UP);
    repeat (2) drive(B_MODE);
    drive(B_SEL);
    repeat (2) drive(B_MODE);
    drive(B_UP);
    check("pre_reset_edit", dut_out, exp_pack(3'd2, 5'd10, 6'd21, 1'b0, 5'd8, 6'd0, 1'b1));
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", dut_out, exp_pack(3'd0, 5'd0, 6'd0, 1'b0, 5'd7, 6'd0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset", dut_out, exp_pack(3'd0, 5'd0, 6'd0, 1'b0, 5'd7, 6'd0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
